// File: rtl/output_manager.sv
// output_manager: captures rendered rows into a ping-pong buffer, hands full rows to the display
// and pulses resume to release the scan source for the next row.
module output_manager #(
    parameter int WIDTH  = 1024,
    parameter int DATA_W = 12,
    parameter int X_W    = 11,
    parameter int Y_W    = 12,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              program_in,
    input  logic [X_W-1:0]    x_in,
    input  logic [Y_W-1:0]    y_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              resume,
    output logic              line_ready,
    output logic [Y_W-1:0]    line_y,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_x,
    output logic [DATA_W-1:0] rd_data,
    input  logic              line_done
);
    typedef enum logic [1:0] {WAIT_ROW, FILL, FULL} state_t;

    state_t            r_state;
    logic              r_wr_bank;
    logic              r_disp_valid;
    logic              r_resume;
    logic [Y_W-1:0]    r_row_y;
    logic [Y_W-1:0]    r_line_y;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_mem [2**(ADDR_W+1)];

    logic w_acc, w_wr, w_swap;

    assign w_acc  = !program_in && (x_in < X_W'(WIDTH));
    assign w_wr   = w_acc && (r_state == FILL || (r_state == WAIT_ROW && x_in == '0));
    // A programming write in the same cycle wins over a pending swap
    assign w_swap = !program_in && r_state == FULL && (!r_disp_valid || line_done);

    assign resume     = r_resume;
    assign line_ready = r_disp_valid;
    assign line_y     = r_line_y;
    assign rd_data    = r_rd_data;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[{r_wr_bank, x_in[ADDR_W-1:0]}] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= WAIT_ROW;
            r_wr_bank    <= 1'b0;
            r_disp_valid <= 1'b0;
            r_resume     <= 1'b0;
            r_row_y      <= '0;
            r_line_y     <= '0;
            r_rd_data    <= '0;
        end else begin
            r_resume <= w_swap;
            if (rd_en) r_rd_data <= r_disp_valid ? r_mem[{~r_wr_bank, rd_x}] : '0;
            if (program_in) begin
                r_state      <= WAIT_ROW;
                r_disp_valid <= 1'b0;
            end else if (w_swap) begin
                r_wr_bank    <= ~r_wr_bank;
                r_disp_valid <= 1'b1;
                r_line_y     <= r_row_y;
                r_state      <= WAIT_ROW;
            end else begin
                if (line_done) r_disp_valid <= 1'b0;
                if (r_state == WAIT_ROW && w_wr) begin
                    r_row_y <= y_in;
                    r_state <= FILL;
                end else if (r_state == FILL && w_acc && x_in == X_W'(WIDTH - 1)) begin
                    r_state <= FULL;
                end
            end
        end
    end
endmodule

// File: tb/tb_output_manager.sv
// tb_output_manager: directed row traffic; expected resume/line_y and read data go through queues.
module tb_output_manager;
    localparam int W = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        program_in;
    logic [10:0] x_in;
    logic [11:0] y_in;
    logic [11:0] data_in;
    logic        resume;
    logic        line_ready;
    logic [11:0] line_y;
    logic        rd_en;
    logic [9:0]  rd_x;
    logic [11:0] rd_data;
    logic        line_done;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [11:0] exp_q[$];
    logic [11:0] rd_q[$];
    logic [11:0] mon_e;

    output_manager dut (
        .clk(clk), .rst_n(rst_n), .program_in(program_in), .x_in(x_in), .y_in(y_in),
        .data_in(data_in), .resume(resume), .line_ready(line_ready), .line_y(line_y),
        .rd_en(rd_en), .rd_x(rd_x), .rd_data(rd_data), .line_done(line_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] dat(input int y, input int x);
        return 12'(x ^ (y * 12'h135));
    endfunction

    task automatic idle();
        program_in = 1'b0;
        x_in       = '1;
        y_in       = '0;
        data_in    = '0;
        rd_en      = 1'b0;
        line_done  = 1'b0;
    endtask

    task automatic px(input int x, input int y, input logic [11:0] d);
        @(negedge clk);
        program_in = 1'b0;
        x_in       = 11'(x);
        y_in       = 12'(y);
        data_in    = d;
    endtask

    task automatic send_row(input int y, input int n);
        for (int i = 0; i < n; i++) px(i, y, dat(y, i));
    endtask

    task automatic rd(input string tag, input int x, input logic [11:0] exp);
        @(negedge clk);
        idle();
        rd_en = 1'b1;
        rd_x  = 10'(x);
        rd_q.push_back(exp);
        @(negedge clk);
        rd_en = 1'b0;
        chk(tag, rd_data, rd_q.pop_front());
    endtask

    task automatic pulse_done();
        @(negedge clk);
        idle();
        line_done = 1'b1;
        @(negedge clk);
        line_done = 1'b0;
    endtask

    // Every resume pulse must match one queued row, with the row's y on line_y
    always @(negedge clk) begin
        if (rst_n && resume) begin
            chk("resume_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("resume_line_y", line_y, mon_e);
                chk("resume_line_ready", line_ready, 1);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        rd_x  = '0;
        idle();
        repeat (3) @(negedge clk);
        chk("rst_line_ready", line_ready, 0);
        chk("rst_line_y", line_y, 0);
        chk("rst_resume", resume, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;

        // Row 0 after reset: display empty, immediate swap two cycles after last pixel
        exp_q.push_back(12'd0);
        send_row(0, W);
        @(negedge clk);
        idle();
        chk("t1_lat_resume_early", resume, 0);
        chk("t1_lat_ready_early", line_ready, 0);
        @(negedge clk);
        chk("t1_lat_resume", resume, 1);
        chk("t1_lat_ready", line_ready, 1);
        repeat (3) @(negedge clk);
        chk("t1_line_y", line_y, 0);
        rd("t1_rd5", 5, 12'd5);
        rd("t1_rd1023", 1023, 12'h3ff);

        // Rows 1 and 2 with the display held: only row 1 swaps until line_done
        pulse_done();
        chk("t2_freed", line_ready, 0);
        exp_q.push_back(12'd1);
        send_row(1, W);
        @(negedge clk);
        idle();
        repeat (4) @(negedge clk);
        chk("t2_line_y1", line_y, 1);
        send_row(2, W);
        @(negedge clk);
        idle();
        repeat (6) @(negedge clk);
        chk("t2_held_line_y", line_y, 1);
        chk("t2_no_resume", 32'(exp_q.size()), 0);
        rd("t2_rd_row1", 7, dat(1, 7));
        exp_q.push_back(12'd2);
        pulse_done();
        chk("t2_release_resume", resume, 1);
        chk("t2_release_line_y", line_y, 2);
        rd("t2_rd_row2", 7, dat(2, 7));

        // Stale x=1023 beats in WAIT_ROW must not start or finish a row
        pulse_done();
        for (int i = 0; i < 10; i++) px(W - 1, 0, 12'habc);
        exp_q.push_back(12'd3);
        send_row(3, W);
        @(negedge clk);
        idle();
        repeat (4) @(negedge clk);
        chk("t3_line_y", line_y, 3);
        rd("t3_rd1023", 1023, dat(3, 1023));
        rd("t3_rd0", 0, dat(3, 0));

        // line_done in the FULL cycle: one swap, line_ready never drops
        exp_q.push_back(12'd4);
        send_row(4, W);
        @(negedge clk);
        idle();
        line_done = 1'b1;
        chk("t4_ready_hold", line_ready, 1);
        @(negedge clk);
        line_done = 1'b0;
        chk("t4_resume", resume, 1);
        chk("t4_ready", line_ready, 1);
        chk("t4_line_y", line_y, 4);
        repeat (3) @(negedge clk);
        rd("t4_rd100", 100, dat(4, 100));

        // Programming traffic mid-row aborts it and drops the displayed row
        send_row(5, 501);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            program_in = 1'b1;
            x_in       = 11'(i * 37);
            y_in       = 12'd9;
            data_in    = 12'($urandom);
        end
        @(negedge clk);
        idle();
        chk("t5_ready_dropped", line_ready, 0);
        chk("t5_no_resume", resume, 0);
        exp_q.push_back(12'd6);
        send_row(6, W);
        @(negedge clk);
        idle();
        repeat (4) @(negedge clk);
        chk("t5_line_y", line_y, 6);
        rd("t5_rd300", 300, dat(6, 300));
        rd("t5_rd1000", 1000, dat(6, 1000));

        // Async reset while a row waits in FULL
        send_row(7, W);
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        chk("t6_full_no_resume", 32'(exp_q.size()), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", line_ready, 0);
        chk("t6_rst_line_y", line_y, 0);
        chk("t6_rst_resume", resume, 0);
        chk("t6_rst_rd_data", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6_idle_ready", line_ready, 0);
        exp_q.push_back(12'd8);
        send_row(8, W);
        @(negedge clk);
        idle();
        repeat (4) @(negedge clk);
        chk("t6_line_y", line_y, 8);
        rd("t6_rd2", 2, dat(8, 2));

        repeat (3) @(negedge clk);
        chk("all_resumes_seen", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
